// File: rtl/mc_chroma_ref_fetch_pkg.sv
// Shared constants and FSM state type for the chroma reference-window fetcher.
package mc_chroma_ref_fetch_pkg;
    localparam int PIXEL_WIDTH = 8;
    localparam int CHROMA_WIN  = 7;
    localparam int WORD_LANES  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RD_LO,
        RD_HI,
        DRAIN
    } state_t;
endpackage

// File: rtl/mc_chroma_row_align.sv
// Picks the 7 window pixels out of a 16-lane {hi,lo} word pair, starting at lane off.
module mc_chroma_row_align
    import mc_chroma_ref_fetch_pkg::*;
#(
    parameter int PIXEL_WIDTH = mc_chroma_ref_fetch_pkg::PIXEL_WIDTH
) (
    input  logic [2*WORD_LANES*PIXEL_WIDTH-1:0] lanes,
    input  logic [2:0]                          off,
    output logic [CHROMA_WIN*PIXEL_WIDTH-1:0]   pix
);
    always_comb begin
        pix = '0;
        for (int unsigned k = 0; k < CHROMA_WIN; k++) begin
            pix[k*PIXEL_WIDTH +: PIXEL_WIDTH] = lanes[(k + 32'(off))*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
    end
endmodule

// File: rtl/mc_chroma_ref_fetch.sv
// Fetches a 7x7 chroma reference window per request and streams it one row per beat.
module mc_chroma_ref_fetch
    import mc_chroma_ref_fetch_pkg::*;
#(
    parameter int PIXEL_WIDTH = mc_chroma_ref_fetch_pkg::PIXEL_WIDTH,
    parameter int ROW_AW      = 6,
    parameter int COL_AW      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic [COL_AW+2:0]             pos_x_i,
    input  logic [ROW_AW-1:0]             pos_y_i,
    input  logic [5:0]                    frac_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          ref_rd_en_o,
    output logic [ROW_AW+COL_AW-1:0]      ref_rd_addr_o,
    input  logic [8*PIXEL_WIDTH-1:0]      ref_rd_data_i,
    output logic                          blk_start_o,
    output logic [5:0]                    frac_o,
    output logic                          refuv_valid_o,
    output logic [PIXEL_WIDTH-1:0]        refuv_p0_o,
    output logic [PIXEL_WIDTH-1:0]        refuv_p1_o,
    output logic [PIXEL_WIDTH-1:0]        refuv_p2_o,
    output logic [PIXEL_WIDTH-1:0]        refuv_p3_o,
    output logic [PIXEL_WIDTH-1:0]        refuv_p4_o,
    output logic [PIXEL_WIDTH-1:0]        refuv_p5_o,
    output logic [PIXEL_WIDTH-1:0]        refuv_p6_o
);
    localparam int WORD_W = WORD_LANES*PIXEL_WIDTH;
    localparam logic [2:0] LAST_ROW = 3'(CHROMA_WIN-1);

    state_t state, state_nx;

    logic [COL_AW+2:0]                x_q;
    logic [ROW_AW-1:0]                y_q;
    logic [5:0]                       frac_q;
    logic [2:0]                       row;
    logic                             row_inc;
    logic                             accept;
    logic                             two_word;
    logic [ROW_AW-1:0]                rd_row;
    logic [COL_AW-1:0]                col_lo, col_hi;
    logic                             rd_lo_q, rd_hi_q, rd_last_q;
    logic [WORD_W-1:0]                lo_q;
    logic                             beat;
    logic [2*WORD_W-1:0]              lanes;
    logic [CHROMA_WIN*PIXEL_WIDTH-1:0] pix, pix_q;
    logic                             valid_q, done_q, blk_q;

    assign two_word = (x_q[2:0] > 3'd1);
    assign col_lo   = x_q[COL_AW+2:3];
    assign col_hi   = col_lo + 1'b1;
    assign rd_row   = y_q + ROW_AW'(row);
    assign accept   = (state == IDLE) && start_i;

    always_comb begin
        state_nx      = state;
        ref_rd_en_o   = 1'b0;
        ref_rd_addr_o = '0;
        row_inc       = 1'b0;
        case (state)
            IDLE: if (start_i) state_nx = RD_LO;
            RD_LO: begin
                ref_rd_en_o   = 1'b1;
                ref_rd_addr_o = {rd_row, col_lo};
                if (two_word) begin
                    state_nx = RD_HI;
                end else begin
                    row_inc  = 1'b1;
                    state_nx = (row == LAST_ROW) ? DRAIN : RD_LO;
                end
            end
            RD_HI: begin
                ref_rd_en_o   = 1'b1;
                ref_rd_addr_o = {rd_row, col_hi};
                row_inc       = 1'b1;
                state_nx      = (row == LAST_ROW) ? DRAIN : RD_LO;
            end
            DRAIN: if (done_q) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // A single-word row is emitted straight from the returning data; a two-word row
    // waits for its hi word and combines it with the registered lo word.
    assign beat  = rd_hi_q || (rd_lo_q && !two_word);
    assign lanes = rd_hi_q ? {ref_rd_data_i, lo_q} : {{WORD_W{1'b0}}, ref_rd_data_i};

    mc_chroma_row_align #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_align (
        .lanes (lanes),
        .off   (x_q[2:0]),
        .pix   (pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x_q       <= '0;
            y_q       <= '0;
            frac_q    <= '0;
            row       <= '0;
            rd_lo_q   <= 1'b0;
            rd_hi_q   <= 1'b0;
            rd_last_q <= 1'b0;
            lo_q      <= '0;
            pix_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            blk_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            blk_q     <= accept;
            rd_lo_q   <= (state == RD_LO);
            rd_hi_q   <= (state == RD_HI);
            rd_last_q <= row_inc && (row == LAST_ROW);
            valid_q   <= beat;
            done_q    <= beat && rd_last_q;
            if (accept) begin
                x_q    <= pos_x_i;
                y_q    <= pos_y_i;
                frac_q <= frac_i;
                row    <= '0;
            end else if (row_inc) begin
                row <= row + 3'd1;
            end
            if (rd_lo_q && two_word) lo_q <= ref_rd_data_i;
            if (beat) pix_q <= pix;
        end
    end

    assign busy_o        = (state != IDLE);
    assign done_o        = done_q;
    assign blk_start_o   = blk_q;
    assign frac_o        = frac_q;
    assign refuv_valid_o = valid_q;
    assign refuv_p0_o    = pix_q[0*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign refuv_p1_o    = pix_q[1*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign refuv_p2_o    = pix_q[2*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign refuv_p3_o    = pix_q[3*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign refuv_p4_o    = pix_q[4*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign refuv_p5_o    = pix_q[5*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign refuv_p6_o    = pix_q[6*PIXEL_WIDTH +: PIXEL_WIDTH];
endmodule
